// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer_if
// Description : Decode/regfile/imem bundle for the next-PC unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              stall;
    logic [3:0]        br_op;
    logic [31:0]       r_s;
    logic [31:0]       r_t;
    logic [15:0]       imm16;
    logic [25:0]       target26;
    logic [ADDR_W-1:0] pc_out;
    logic [2:0]        phase;
    logic              fetch_en;
    logic              link_we;
    logic [31:0]       link_data;
    logic              redirect;
    logic              addr_err;

    modport master (
        output stall, br_op, r_s, r_t, imm16, target26,
        input  pc_out, phase, fetch_en, link_we, link_data, redirect, addr_err
    );

    modport slave (
        input  stall, br_op, r_s, r_t, imm16, target26,
        output pc_out, phase, fetch_en, link_we, link_data, redirect, addr_err
    );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program counter, FETCH/EXEC phase counter and jump/branch
//               resolution for the multi-cycle core. Define DELAY_SLOT_EN
//               for architectural branch-delay-slot behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter int                EXEC_CYCLES  = 2
) (
    input  logic          clk,
    input  logic          rst,
    pc_sequencer_if.slave bus
);
    localparam logic [2:0] c_last_phase = 3'(EXEC_CYCLES);

    localparam logic [3:0] c_op_j      = 4'd1;
    localparam logic [3:0] c_op_jal    = 4'd2;
    localparam logic [3:0] c_op_jr     = 4'd3;
    localparam logic [3:0] c_op_jalr   = 4'd4;
    localparam logic [3:0] c_op_beq    = 4'd5;
    localparam logic [3:0] c_op_bne    = 4'd6;
    localparam logic [3:0] c_op_bgez   = 4'd7;
    localparam logic [3:0] c_op_bgezal = 4'd8;
    localparam logic [3:0] c_op_bgtz   = 4'd9;
    localparam logic [3:0] c_op_blez   = 4'd10;
    localparam logic [3:0] c_op_bltz   = 4'd11;
    localparam logic [3:0] c_op_bltzal = 4'd12;

    logic [ADDR_W-1:0] r_pc;
    logic [2:0]        r_phase;

    logic [ADDR_W-1:0] w_pc4;
    logic [ADDR_W-1:0] w_jump_target;
    logic [ADDR_W-1:0] w_reg_target;
    logic [ADDR_W-1:0] w_branch_target;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_next_pc;
    logic [ADDR_W-1:0] w_ret_addr;
    logic              w_commit;
    logic              w_taken;
    logic              w_link;
    logic              w_is_jr;
    logic              w_link_we;
    logic              w_rs_zero;

    assign w_pc4           = r_pc + ADDR_W'(4);
    assign w_reg_target    = ADDR_W'(bus.r_s & 32'hFFFF_FFFC);
    assign w_branch_target = w_pc4 + ADDR_W'($signed({{14{bus.imm16[15]}}, bus.imm16, 2'b00}));
    assign w_rs_zero       = (bus.r_s == 32'd0);

    // The J-type region bits above 28 only exist when the PC is wider than 28.
    generate
        if (ADDR_W == 28) begin : g_jump_narrow
            assign w_jump_target = {bus.target26, 2'b00};
        end else begin : g_jump_wide
            assign w_jump_target = {w_pc4[ADDR_W-1:28], bus.target26, 2'b00};
        end
    endgenerate

    always_comb begin
        w_taken  = 1'b0;
        w_link   = 1'b0;
        w_target = w_branch_target;
        case (bus.br_op)
            c_op_j:      begin w_taken = 1'b1; w_target = w_jump_target; end
            c_op_jal:    begin w_taken = 1'b1; w_link = 1'b1; w_target = w_jump_target; end
            c_op_jr:     begin w_taken = 1'b1; w_target = w_reg_target; end
            c_op_jalr:   begin w_taken = 1'b1; w_link = 1'b1; w_target = w_reg_target; end
            c_op_beq:    w_taken = (bus.r_s == bus.r_t);
            c_op_bne:    w_taken = (bus.r_s != bus.r_t);
            c_op_bgez:   w_taken = ~bus.r_s[31];
            c_op_bgezal: begin w_taken = ~bus.r_s[31]; w_link = 1'b1; end
            c_op_bgtz:   w_taken = ~bus.r_s[31] & ~w_rs_zero;
            c_op_blez:   w_taken = bus.r_s[31] | w_rs_zero;
            c_op_bltz:   w_taken = bus.r_s[31];
            c_op_bltzal: begin w_taken = bus.r_s[31]; w_link = 1'b1; end
            default:     w_taken = 1'b0;
        endcase
    end

    assign w_is_jr  = (bus.br_op == c_op_jr) || (bus.br_op == c_op_jalr);
    assign w_commit = ~rst & ~bus.stall & (r_phase == c_last_phase);

`ifdef DELAY_SLOT_EN
    logic              r_pend_valid;
    logic [ADDR_W-1:0] r_pend_target;

    // An instruction committing while a target is pending sits in the delay
    // slot: its own control transfer and link are dropped.
    assign w_link_we    = w_commit & w_link & ~r_pend_valid;
    assign bus.redirect = w_commit & r_pend_valid;
    assign w_ret_addr   = r_pc + ADDR_W'(8);
    assign w_next_pc    = r_pend_valid ? r_pend_target : w_pc4;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_valid  <= 1'b0;
            r_pend_target <= '0;
        end else if (w_commit) begin
            if (r_pend_valid) begin
                r_pend_valid <= 1'b0;
            end else if (w_taken) begin
                r_pend_valid  <= 1'b1;
                r_pend_target <= w_target;
            end
        end
    end
`else
    assign w_link_we    = w_commit & w_link;
    assign bus.redirect = w_commit & w_taken;
    assign w_ret_addr   = w_pc4;
    assign w_next_pc    = w_taken ? w_target : w_pc4;
`endif

    assign bus.link_we   = w_link_we;
    assign bus.link_data = w_link_we ? 32'(w_ret_addr) : 32'd0;
    assign bus.addr_err  = w_commit & w_is_jr & (|bus.r_s[1:0]);
    assign bus.pc_out    = r_pc;
    assign bus.phase     = r_phase;
    assign bus.fetch_en  = (r_phase == 3'd0) & ~bus.stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_VECTOR;
            r_phase <= 3'd0;
        end else if (!bus.stall) begin
            r_phase <= (r_phase == c_last_phase) ? 3'd0 : r_phase + 3'd1;
            if (w_commit) begin
                r_pc <= w_next_pc;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Vector table, hand sequences and randomized run of
//               pc_sequencer against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;
    localparam int c_exec = 2;

    localparam logic [3:0] c_none = 4'd0, c_j = 4'd1, c_jal = 4'd2, c_jr = 4'd3,
                           c_jalr = 4'd4, c_beq = 4'd5, c_bne = 4'd6, c_bgez = 4'd7,
                           c_bgezal = 4'd8, c_bgtz = 4'd9, c_blez = 4'd10,
                           c_bltz = 4'd11, c_bltzal = 4'd12;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    logic [31:0] m_pc;
    logic [31:0] pend_q[$];

    logic        obs_link_we, obs_redirect, obs_err;
    logic [31:0] obs_link_data;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] start_pc;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] exp_pc;
        logic        exp_link;
        logic [31:0] exp_ld;
        logic        exp_err;
    } vec_t;
    vec_t vecs[$];

    pc_sequencer_if #(.ADDR_W(32)) bus ();

    pc_sequencer #(
        .ADDR_W      (32),
        .RESET_VECTOR(32'h0000_0000),
        .EXEC_CYCLES (c_exec)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tv(input string nm, input logic [3:0] op, input logic [31:0] sp,
                      input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic [31:0] epc, input logic elink,
                      input logic [31:0] eld, input logic eerr);
        vec_t v;
        v.name = nm; v.op = op; v.start_pc = sp; v.rs = rs; v.rt = rt; v.imm = imm;
        v.tgt = tgt; v.exp_pc = epc; v.exp_link = elink; v.exp_ld = eld; v.exp_err = eerr;
        vecs.push_back(v);
    endtask

    // One whole instruction, checked every cycle against the reference model.
    task automatic run_instr(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                             input logic [15:0] imm, input logic [25:0] tgt, input bit allow_stall);
        logic [31:0] pc4, target, next_pc, exp_ld;
        bit taken, lnk, err, redir, slot, st, commit;
        int c, guard;
        bus.br_op = op; bus.r_s = rs; bus.r_t = rt; bus.imm16 = imm; bus.target26 = tgt;
        pc4    = m_pc + 32'd4;
        taken  = 1'b0;
        target = pc4 + 32'(int'($signed(imm)) * 4);
        case (op)
            c_j, c_jal:          begin taken = 1'b1; target = {pc4[31:28], tgt, 2'b00}; end
            c_jr, c_jalr:        begin taken = 1'b1; target = rs & ~32'd3; end
            c_beq:               taken = (rs == rt);
            c_bne:               taken = (rs != rt);
            c_bgez, c_bgezal:    taken = ($signed(rs) >= 0);
            c_bgtz:              taken = ($signed(rs) > 0);
            c_blez:              taken = ($signed(rs) <= 0);
            c_bltz, c_bltzal:    taken = ($signed(rs) < 0);
            default:             taken = 1'b0;
        endcase
        lnk = (op == c_jal) || (op == c_jalr) || (op == c_bgezal) || (op == c_bltzal);
        err = ((op == c_jr) || (op == c_jalr)) && (rs[1:0] != 2'b00);
`ifdef DELAY_SLOT_EN
        slot    = (pend_q.size() != 0);
        next_pc = slot ? pend_q[0] : pc4;
        redir   = slot;
        if (slot) lnk = 1'b0;
        exp_ld  = m_pc + 32'd8;
`else
        slot    = 1'b0;
        next_pc = taken ? target : pc4;
        redir   = taken;
        exp_ld  = pc4;
`endif
        c = 0;
        guard = 0;
        while (c <= c_exec) begin
            st = allow_stall && ($urandom_range(3) == 0);
            bus.stall = st;
            #1;
            commit = !st && (c == c_exec);
            chk("phase", 32'(bus.phase), 32'(c));
            chk("pc_out", bus.pc_out, m_pc);
            chk("fetch_en", 32'(bus.fetch_en), 32'(!st && c == 0));
            chk("link_we", 32'(bus.link_we), 32'(commit && lnk));
            chk("redirect", 32'(bus.redirect), 32'(commit && redir));
            chk("addr_err", 32'(bus.addr_err), 32'(commit && err));
            if (commit && lnk) chk("link_data", bus.link_data, exp_ld);
            if (commit) begin
                obs_link_we = bus.link_we; obs_link_data = bus.link_data;
                obs_redirect = bus.redirect; obs_err = bus.addr_err;
            end
            tick();
            if (commit) begin
                m_pc = next_pc;
`ifdef DELAY_SLOT_EN
                if (slot) void'(pend_q.pop_front());
                else if (taken) pend_q.push_back(target);
`endif
            end
            if (!st) c++;
            guard++;
            if (guard > 100) begin
                chk("instr_budget", 32'(guard), 32'(c_exec + 1));
                break;
            end
        end
        bus.stall = 1'b0;
    endtask

    task automatic goto_pc(input logic [31:0] addr);
        if (pend_q.size() != 0) run_instr(c_none, 32'd0, 32'd0, 16'd0, 26'd0, 1'b0);
        run_instr(c_jr, addr, 32'd0, 16'd0, 26'd0, 1'b0);
`ifdef DELAY_SLOT_EN
        run_instr(c_none, 32'd0, 32'd0, 16'd0, 26'd0, 1'b0);
`endif
    endtask

    initial begin
        logic [31:0] rs, rt, exp_next;
        // ---------------- reset (stall high must be ignored) ----------------
        rst = 1'b1; bus.stall = 1'b1; bus.br_op = c_jalr; bus.r_s = 32'h203; bus.r_t = 32'd0;
        bus.imm16 = 16'd0; bus.target26 = 26'd0;
        tick(); tick(); #1;
        chk("rst_link_we", 32'(bus.link_we), 32'd0);
        chk("rst_redirect", 32'(bus.redirect), 32'd0);
        chk("rst_addr_err", 32'(bus.addr_err), 32'd0);
        chk("rst_link_data", bus.link_data, 32'd0);
        chk("rst_pc", bus.pc_out, 32'd0);
        chk("rst_phase", 32'(bus.phase), 32'd0);
        rst = 1'b0; bus.stall = 1'b0; m_pc = 32'd0;

        // ---------------- sequential NONE instructions ----------------
        for (int i = 0; i < 3; i++) run_instr(c_none, 32'd0, 32'd0, 16'd0, 26'd0, 1'b0);
        #1 chk("none_seq_pc", bus.pc_out, 32'd12);

        // ---------------- vector table (expectations for no delay slot) ----------------
        tv("bne_taken",   c_bne,    32'h40,        32'd1,         32'd2, 16'hFFFF, 26'd0,       32'h40,        0, 0,      0);
        tv("bgtz_neg",    c_bgtz,   32'h40,        32'h8000_0000, 32'd0, 16'h0010, 26'd0,       32'h44,        0, 0,      0);
        tv("jal",         c_jal,    32'h100,       32'd0,         32'd0, 16'h0000, 26'h10,      32'h40,        1, 32'h104, 0);
        tv("jr_misalign", c_jr,     32'h80,        32'h203,       32'd0, 16'h0000, 26'd0,       32'h200,       0, 0,      1);
        tv("beq_taken",   c_beq,    32'h20,        32'd5,         32'd5, 16'h0004, 26'd0,       32'h34,        0, 0,      0);
        tv("beq_not",     c_beq,    32'h20,        32'd5,         32'd6, 16'h0004, 26'd0,       32'h24,        0, 0,      0);
        tv("bgez_zero",   c_bgez,   32'h300,       32'd0,         32'd0, 16'hFFFE, 26'd0,       32'h2FC,       0, 0,      0);
        tv("bltz_m1",     c_bltz,   32'h10,        32'hFFFF_FFFF, 32'd0, 16'h0002, 26'd0,       32'h1C,        0, 0,      0);
        tv("blez_zero",   c_blez,   32'h10,        32'd0,         32'd0, 16'h0001, 26'd0,       32'h18,        0, 0,      0);
        tv("bltzal_not",  c_bltzal, 32'h50,        32'd1,         32'd0, 16'h0010, 26'd0,       32'h54,        1, 32'h54, 0);
        tv("bgezal_tk",   c_bgezal, 32'h50,        32'd7,         32'd0, 16'h0003, 26'd0,       32'h60,        1, 32'h54, 0);
        tv("jalr_mis",    c_jalr,   32'h60,        32'h1001,      32'd0, 16'h0000, 26'd0,       32'h1000,      1, 32'h64, 1);
        tv("op13_none",   4'd13,    32'h60,        32'd0,         32'd0, 16'h0008, 26'h1,       32'h64,        0, 0,      0);
        tv("j_region",    c_j,      32'hF000_0000, 32'd0,         32'd0, 16'h0000, 26'h3FFFFFF, 32'hFFFF_FFFC, 0, 0,      0);
        tv("bne_wrap",    c_bne,    32'hFFFF_FFFC, 32'd1,         32'd0, 16'h0001, 26'd0,       32'h4,         0, 0,      0);
        tv("bgtz_pos",    c_bgtz,   32'h0,         32'd1,         32'd0, 16'h0010, 26'd0,       32'h44,        0, 0,      0);
        for (int i = 0; i < vecs.size(); i++) begin
            goto_pc(vecs[i].start_pc);
            run_instr(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].imm, vecs[i].tgt, 1'b0);
            chk({vecs[i].name, "_link_we"}, 32'(obs_link_we), 32'(vecs[i].exp_link));
            chk({vecs[i].name, "_addr_err"}, 32'(obs_err), 32'(vecs[i].exp_err));
`ifdef DELAY_SLOT_EN
            if (vecs[i].exp_link) chk({vecs[i].name, "_link_data"}, obs_link_data, vecs[i].exp_ld + 32'd4);
            #1 chk({vecs[i].name, "_pc_slot"}, bus.pc_out, vecs[i].start_pc + 32'd4);
            run_instr(c_none, 32'd0, 32'd0, 16'd0, 26'd0, 1'b0);
            #1 chk({vecs[i].name, "_pc"}, bus.pc_out,
                   (vecs[i].exp_pc == vecs[i].start_pc + 32'd4) ? vecs[i].start_pc + 32'd8 : vecs[i].exp_pc);
`else
            if (vecs[i].exp_link) chk({vecs[i].name, "_link_data"}, obs_link_data, vecs[i].exp_ld);
            #1 chk({vecs[i].name, "_pc"}, bus.pc_out, vecs[i].exp_pc);
`endif
        end

`ifdef DELAY_SLOT_EN
        // ---------------- branches sitting in a delay slot ----------------
        goto_pc(32'h20);
        run_instr(c_beq, 32'd5, 32'd5, 16'd4, 26'd0, 1'b0);
        #1 chk("ds_beq_pc", bus.pc_out, 32'h24);
        run_instr(c_j, 32'd0, 32'd0, 16'd0, 26'h100, 1'b0);
        chk("ds_j_redirect", 32'(obs_redirect), 32'd1);
        #1 chk("ds_j_pc", bus.pc_out, 32'h34);
        run_instr(c_bne, 32'd1, 32'd0, 16'd8, 26'd0, 1'b0);
        run_instr(c_jalr, 32'h203, 32'd0, 16'd0, 26'd0, 1'b0);
        chk("ds_jalr_link", 32'(obs_link_we), 32'd0);
        chk("ds_jalr_err", 32'(obs_err), 32'd1);
        #1 chk("ds_jalr_pc", bus.pc_out, 32'h58);
`endif

        // ---------------- stall held 5 clocks in EXEC2 ----------------
        goto_pc(32'h100);
        bus.br_op = c_jal; bus.target26 = 26'h10; bus.stall = 1'b0;
        tick(); tick();
        bus.stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_phase", 32'(bus.phase), 32'd2);
            chk("stall_pc", bus.pc_out, 32'h100);
            chk("stall_link_we", 32'(bus.link_we), 32'd0);
            tick();
        end
        bus.stall = 1'b0;
        #1;
        chk("stall_commit_link_we", 32'(bus.link_we), 32'd1);
`ifdef DELAY_SLOT_EN
        chk("stall_commit_link_data", bus.link_data, 32'h108);
        exp_next = 32'h104;
        pend_q.push_back(32'h40);
`else
        chk("stall_commit_link_data", bus.link_data, 32'h104);
        exp_next = 32'h40;
`endif
        tick(); #1;
        chk("stall_next_pc", bus.pc_out, exp_next);
        chk("stall_link_pulse", 32'(bus.link_we), 32'd0);
        m_pc = exp_next;

        // ---------------- reset mid-EXEC1 ----------------
        goto_pc(32'h500);
        bus.br_op = c_jal; bus.target26 = 26'h10;
        tick();
        rst = 1'b1; #1;
        chk("rst_e1_link_we", 32'(bus.link_we), 32'd0);
        chk("rst_e1_redirect", 32'(bus.redirect), 32'd0);
        tick(); rst = 1'b0; #1;
        chk("rst_e1_pc", bus.pc_out, 32'd0);
        chk("rst_e1_phase", 32'(bus.phase), 32'd0);
        m_pc = 32'd0; pend_q.delete();
        run_instr(c_none, 32'd0, 32'd0, 16'd0, 26'd0, 1'b0);

        // ---------------- reset in the commit phase ----------------
        goto_pc(32'h600);
        bus.br_op = c_jalr; bus.r_s = 32'h203;
        tick(); tick();
        rst = 1'b1; #1;
        chk("rst_e2_link_we", 32'(bus.link_we), 32'd0);
        chk("rst_e2_addr_err", 32'(bus.addr_err), 32'd0);
        chk("rst_e2_redirect", 32'(bus.redirect), 32'd0);
        chk("rst_e2_link_data", bus.link_data, 32'd0);
        tick(); rst = 1'b0; #1;
        chk("rst_e2_pc", bus.pc_out, 32'd0);
        m_pc = 32'd0; pend_q.delete();

        // ---------------- randomized run with random stalls ----------------
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(4))
                0:       rs = 32'd0;
                1:       rs = $urandom;
                2:       rs = 32'd0 - 32'($urandom_range(8));
                3:       rs = 32'($urandom_range(4096));
                default: rs = 32'h8000_0000;
            endcase
            rt = ($urandom_range(1) == 0) ? rs : $urandom;
            run_instr(4'($urandom_range(15)), rs, rt, 16'($urandom), 26'($urandom), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
